// File: rtl/reg_rename_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_rename_file_if
// Description : Issue / commit / flush request bundle into the rename register
//               file and the registered operand bundle it returns to the ROB.
//               master : issue/commit source (ROB / dispatch side)
//               slave  : the register file itself
// Revision    : 1.0  initial release
// ============================================================================
interface reg_rename_file_if #(
    parameter int REG_BIT   = 5,
    parameter int ROB_BIT   = 5,
    parameter int REG_DAT_W = 32,
    parameter int OP_W      = 6
);
    // issue request
    logic                 is_en_i;
    logic [REG_BIT-1:0]   is_rs1_i;
    logic [REG_BIT-1:0]   is_rs2_i;
    logic [REG_BIT-1:0]   is_rd_i;
    logic [ROB_BIT-1:0]   is_qd_i;
    logic [OP_W-1:0]      is_op_i;
    logic [REG_DAT_W-1:0] is_imm_i;
    // commit write from the ROB head
    logic                 cmt_en_i;
    logic [REG_BIT-1:0]   cmt_rd_i;
    logic [ROB_BIT-1:0]   cmt_q_i;
    logic [REG_DAT_W-1:0] cmt_v_i;
    // misprediction flush
    logic                 br_flag_i;
    // operand bundle to the ROB
    logic                 rob_en_o;
    logic [ROB_BIT-1:0]   rob_qj_o;
    logic [ROB_BIT-1:0]   rob_qk_o;
    logic [REG_DAT_W-1:0] rob_vj_o;
    logic [REG_DAT_W-1:0] rob_vk_o;
    logic [ROB_BIT-1:0]   rob_qd_o;
    logic [OP_W-1:0]      rob_op_o;
    logic [REG_DAT_W-1:0] rob_imm_o;

    modport master (
        output is_en_i, is_rs1_i, is_rs2_i, is_rd_i, is_qd_i, is_op_i, is_imm_i,
        output cmt_en_i, cmt_rd_i, cmt_q_i, cmt_v_i, br_flag_i,
        input  rob_en_o, rob_qj_o, rob_qk_o, rob_vj_o, rob_vk_o,
        input  rob_qd_o, rob_op_o, rob_imm_o
    );

    modport slave (
        input  is_en_i, is_rs1_i, is_rs2_i, is_rd_i, is_qd_i, is_op_i, is_imm_i,
        input  cmt_en_i, cmt_rd_i, cmt_q_i, cmt_v_i, br_flag_i,
        output rob_en_o, rob_qj_o, rob_qk_o, rob_vj_o, rob_vk_o,
        output rob_qd_o, rob_op_o, rob_imm_o
    );
endinterface
`default_nettype wire

// File: rtl/reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_rename_file
// Description : Architectural register file with per-register rename tags.
//               Resolves two source operands per issue (tag or value, with
//               commit bypass), renames rd to the allocated ROB tag, accepts
//               one commit write per cycle and clears all tags on a flush.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               en   - global enable (low holds all state, no bundle)
//               bus  - reg_rename_file_if.slave (issue, commit, flush in;
//                      registered operand bundle out)
// Revision    : 1.0  initial release
// ============================================================================
module reg_rename_file #(
    parameter int REG_BIT   = 5,
    parameter int ROB_BIT   = 5,
    parameter int REG_DAT_W = 32,
    parameter int OP_W      = 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          en,
    reg_rename_file_if.slave   bus
);
    localparam int NUM_REG = 1 << REG_BIT;

    logic [REG_DAT_W-1:0] v [NUM_REG];
    logic [ROB_BIT-1:0]   q [NUM_REG];

    logic [ROB_BIT-1:0]   qj, qk;
    logic [REG_DAT_W-1:0] vj, vk;
    logic                 cmt_wr;
    logic                 cmt_clr;

    logic                 rob_en;
    logic [ROB_BIT-1:0]   rob_qj, rob_qk, rob_qd;
    logic [REG_DAT_W-1:0] rob_vj, rob_vk, rob_imm;
    logic [OP_W-1:0]      rob_op;

    // Resolve one source on the pre-edge state. A commit whose tag matches the
    // register's current producer is forwarded straight into the bundle.
    function automatic logic [ROB_BIT+REG_DAT_W-1:0] resolve(
        input logic [REG_BIT-1:0]   rs,
        input logic [ROB_BIT-1:0]   q_rs,
        input logic [REG_DAT_W-1:0] v_rs,
        input logic                 c_en,
        input logic [REG_BIT-1:0]   c_rd,
        input logic [ROB_BIT-1:0]   c_q,
        input logic [REG_DAT_W-1:0] c_v
    );
        if (rs == '0)
            return '0;
        else if (c_en && c_rd == rs && q_rs == c_q)
            return {{ROB_BIT{1'b0}}, c_v};
        else if (q_rs == '0)
            return {{ROB_BIT{1'b0}}, v_rs};
        else
            return {q_rs, {REG_DAT_W{1'b0}}};
    endfunction

    always_comb begin
        {qj, vj} = resolve(bus.is_rs1_i, q[bus.is_rs1_i], v[bus.is_rs1_i],
                           bus.cmt_en_i, bus.cmt_rd_i, bus.cmt_q_i, bus.cmt_v_i);
        {qk, vk} = resolve(bus.is_rs2_i, q[bus.is_rs2_i], v[bus.is_rs2_i],
                           bus.cmt_en_i, bus.cmt_rd_i, bus.cmt_q_i, bus.cmt_v_i);
    end

    // A commit clears the tag only when it is still the latest producer and
    // the same-cycle issue is not renaming that register again.
    assign cmt_wr  = bus.cmt_en_i && (bus.cmt_rd_i != '0);
    assign cmt_clr = cmt_wr && (q[bus.cmt_rd_i] == bus.cmt_q_i) &&
                     !(bus.is_en_i && (bus.is_rd_i == bus.cmt_rd_i));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REG; i++) begin
                v[i] <= '0;
                q[i] <= '0;
            end
            rob_en  <= 1'b0;
            rob_qj  <= '0;
            rob_qk  <= '0;
            rob_vj  <= '0;
            rob_vk  <= '0;
            rob_qd  <= '0;
            rob_op  <= '0;
            rob_imm <= '0;
        end else if (en) begin
            rob_en <= 1'b0;
            // Committed values are kept even across a flush.
            if (cmt_wr)
                v[bus.cmt_rd_i] <= bus.cmt_v_i;
            if (bus.br_flag_i) begin
                for (int i = 0; i < NUM_REG; i++)
                    q[i] <= '0;
            end else begin
                if (cmt_clr)
                    q[bus.cmt_rd_i] <= '0;
                if (bus.is_en_i && bus.is_rd_i != '0)
                    q[bus.is_rd_i] <= bus.is_qd_i;
                if (bus.is_en_i) begin
                    rob_en  <= 1'b1;
                    rob_qj  <= qj;
                    rob_qk  <= qk;
                    rob_vj  <= vj;
                    rob_vk  <= vk;
                    rob_qd  <= bus.is_qd_i;
                    rob_op  <= bus.is_op_i;
                    rob_imm <= bus.is_imm_i;
                end
            end
        end else begin
            rob_en <= 1'b0;
        end
    end

    assign bus.rob_en_o  = rob_en;
    assign bus.rob_qj_o  = rob_qj;
    assign bus.rob_qk_o  = rob_qk;
    assign bus.rob_vj_o  = rob_vj;
    assign bus.rob_vk_o  = rob_vk;
    assign bus.rob_qd_o  = rob_qd;
    assign bus.rob_op_o  = rob_op;
    assign bus.rob_imm_o = rob_imm;

endmodule
`default_nettype wire

// File: tb/tb_reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_rename_file
// Description : Self-checking bench for reg_rename_file. A reference model of
//               the register/tag state predicts each operand bundle, queues it
//               at issue and compares it when the DUT presents rob_en_o.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_rename_file;
    logic clk;
    logic rst;
    logic en;

    reg_rename_file_if #(.REG_BIT(5), .ROB_BIT(5), .REG_DAT_W(32), .OP_W(6)) bus ();

    reg_rename_file #(.REG_BIT(5), .ROB_BIT(5), .REG_DAT_W(32), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  mv [32];
    logic [4:0]   mq [32];
    logic [127:0] exp_q [$];
    logic [127:0] last_bundle;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dut_bundle();
        return {11'b0, bus.rob_qj_o, bus.rob_qk_o, bus.rob_vj_o, bus.rob_vk_o,
                bus.rob_qd_o, bus.rob_op_o, bus.rob_imm_o};
    endfunction

    function automatic logic [36:0] model_src(input logic [4:0] rs);
        if (rs == 5'd0) return '0;
        if (bus.cmt_en_i && bus.cmt_rd_i == rs && mq[rs] == bus.cmt_q_i) return {5'd0, bus.cmt_v_i};
        if (mq[rs] == 5'd0) return {5'd0, mv[rs]};
        return {mq[rs], 32'd0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mv[i] = '0;
            mq[i] = '0;
        end
        exp_q.delete();
        last_bundle = '0;
    endtask

    task automatic idle();
        bus.is_en_i = 0; bus.is_rs1_i = 0; bus.is_rs2_i = 0; bus.is_rd_i = 0;
        bus.is_qd_i = 0; bus.is_op_i = 0; bus.is_imm_i = 0;
        bus.cmt_en_i = 0; bus.cmt_rd_i = 0; bus.cmt_q_i = 0; bus.cmt_v_i = 0;
        bus.br_flag_i = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [4:0] qd);
        bus.is_en_i = 1; bus.is_rs1_i = rs1; bus.is_rs2_i = rs2; bus.is_rd_i = rd;
        bus.is_qd_i = qd; bus.is_op_i = 6'($urandom); bus.is_imm_i = $urandom;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] q, input logic [31:0] v);
        bus.cmt_en_i = 1; bus.cmt_rd_i = rd; bus.cmt_q_i = q; bus.cmt_v_i = v;
    endtask

    // Predict from current inputs, advance the model, clock, then compare.
    task automatic step();
        logic        exp_v;
        logic [36:0] s1, s2;
        logic        clr;
        exp_v = 1'b0;
        if (en) begin
            if (!bus.br_flag_i && bus.is_en_i) begin
                s1 = model_src(bus.is_rs1_i);
                s2 = model_src(bus.is_rs2_i);
                exp_q.push_back({11'b0, s1[36:32], s2[36:32], s1[31:0], s2[31:0],
                                 bus.is_qd_i, bus.is_op_i, bus.is_imm_i});
                exp_v = 1'b1;
            end
            clr = bus.cmt_en_i && bus.cmt_rd_i != 0 && mq[bus.cmt_rd_i] == bus.cmt_q_i &&
                  !(bus.is_en_i && bus.is_rd_i == bus.cmt_rd_i);
            if (bus.cmt_en_i && bus.cmt_rd_i != 0) mv[bus.cmt_rd_i] = bus.cmt_v_i;
            if (bus.br_flag_i) begin
                for (int i = 0; i < 32; i++) mq[i] = '0;
            end else begin
                if (clr) mq[bus.cmt_rd_i] = '0;
                if (bus.is_en_i && bus.is_rd_i != 0) mq[bus.is_rd_i] = bus.is_qd_i;
            end
        end
        @(posedge clk);
        #1;
        check("rob_en", {127'b0, bus.rob_en_o}, {127'b0, exp_v});
        if (bus.rob_en_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bundle", 128'd1, 128'd0);
            end else begin
                last_bundle = exp_q.pop_front();
                check("bundle", dut_bundle(), last_bundle);
            end
        end else begin
            check("hold", dut_bundle(), last_bundle);
        end
        idle();
    endtask

    initial begin
        idle();
        en  = 1;
        rst = 1;
        model_reset();
        #1 rst = 0;
        #1;
        check("reset_en", {127'b0, bus.rob_en_o}, 128'd0);
        check("reset_bundle", dut_bundle(), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;

        // reset state read
        issue(3, 4, 0, 1); step();
        // rename then dependent read (back-to-back)
        issue(1, 2, 5, 7); step();
        issue(5, 0, 0, 2); step();
        commit(5, 7, 32'h1234); step();
        issue(5, 5, 0, 3); step();
        // bypass with same-cycle commit
        issue(0, 0, 5, 9); step();
        commit(5, 9, 32'hAA); issue(5, 5, 0, 4); step();
        // stale commit keeps the newer tag
        issue(0, 0, 5, 9); step();
        commit(5, 7, 32'h55); step();
        issue(5, 1, 0, 5); step();
        commit(5, 9, 32'h66); step();
        issue(5, 0, 0, 6); step();
        // self dependency with commit/rename conflict
        issue(0, 0, 6, 2); step();
        commit(6, 2, 32'hBEEF); issue(6, 6, 6, 11); step();
        issue(6, 5, 0, 12); step();
        // x0 is immutable
        issue(0, 0, 0, 4); step();
        issue(0, 0, 0, 13); step();
        commit(0, 0, 32'hFF); step();
        issue(0, 0, 0, 14); step();
        // flush
        issue(0, 0, 1, 3); step();
        issue(0, 0, 2, 8); step();
        commit(1, 30, 32'h111); step();
        bus.br_flag_i = 1; issue(1, 2, 3, 15); step();
        issue(1, 2, 0, 16); step();
        // global enable low holds state and suppresses the bundle
        en = 0; issue(1, 2, 7, 17); commit(2, 0, 32'h222); step();
        step();
        en = 1; issue(7, 2, 0, 18); step();

        // randomized mix
        for (int n = 0; n < 200; n++) begin
            logic [4:0] crd;
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) != 0)
                issue(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)));
            if ($urandom_range(0, 1) != 0) begin
                crd = 5'($urandom);
                commit(crd, ($urandom_range(0, 3) != 0) ? mq[crd] : 5'($urandom), $urandom);
            end
            bus.br_flag_i = ($urandom_range(0, 15) == 0);
            step();
        end
        en = 1;

        // asynchronous reset mid-operation
        issue(0, 0, 9, 20); step();
        #2 rst = 0;
        #1;
        check("midreset_en", {127'b0, bus.rob_en_o}, 128'd0);
        check("midreset_bundle", dut_bundle(), 128'd0);
        model_reset();
        @(negedge clk) rst = 1;
        issue(9, 9, 0, 21); step();

        check("drain", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
